// File: rtl/bitonic_pkg.sv
// Shared types and constants for the 16-element bitonic sort pipeline.
// The loader, the sorter and the downstream result stage all use these types.
package bitonic_pkg;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int IDX_W = $clog2(N);
  // One extra bit so that a full frame can report a count of exactly N.
  localparam int CNT_W = $clog2(N) + 1;

  typedef logic [W-1:0]     elem_t;
  typedef elem_t            frame_t [0:N-1];
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Pad value for unused slots; it sorts to the tail in an ascending sort.
  localparam elem_t PAD_VALUE = 8'hFF;

  // Number of real elements in a frame whose final beat landed in slot idx.
  function automatic cnt_t slot_count(input idx_t idx);
    return cnt_t'(idx) + cnt_t'(1);
  endfunction

endpackage

// File: rtl/bitonic_frame_loader_if.sv
// Byte-stream valid/ready link that feeds the frame loader.
// The source drives master; the loader takes slave.
interface bitonic_frame_loader_if;
  import bitonic_pkg::*;

  logic  in_valid;
  logic  in_ready;
  elem_t in_data;
  logic  in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/bitonic_frame_loader.sv
// Assembles a byte stream into frames for the bitonic sorter: fill buffer, pad-on-transfer
// into a held output register, and a hold counter that reports when the sorter has settled.
module bitonic_frame_loader
  import bitonic_pkg::*;
#(
  parameter int SORT_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bitonic_frame_loader_if.slave        in_bus,
  output frame_t                       frame_out,
  output cnt_t                         frame_count,
  output logic                         frame_start,
  output logic                         frame_settled
);

  localparam int HOLD_W = $clog2(SORT_LATENCY + 1);
  typedef logic [HOLD_W-1:0] hold_t;

  elem_t  fbuf_q [0:N-1];
  frame_t padded;

  idx_t   wr_idx_q,   wr_idx_d;
  logic   pending_q,  pending_d;
  cnt_t   pend_cnt_q, pend_cnt_d;
  hold_t  hold_cnt_q, hold_cnt_d;
  logic   loaded_q,   loaded_d;
  frame_t frame_q,    frame_d;
  cnt_t   count_q,    count_d;
  logic   start_q,    start_d;

  logic   accept;
  logic   frame_done;
  logic   transfer;

  assign in_bus.in_ready = !pending_q;
  assign accept          = in_bus.in_valid && !pending_q;
  assign frame_done      = accept && (in_bus.in_last || (wr_idx_q == idx_t'(N - 1)));
  assign transfer        = pending_q && (hold_cnt_q == '0);

  // Stale slots from an earlier, longer frame are masked here rather than cleared in fbuf.
  for (genvar gi = 0; gi < N; gi++) begin : g_pad
    assign padded[gi] = (cnt_t'(gi) < pend_cnt_q) ? fbuf_q[gi] : PAD_VALUE;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fbuf_q[wr_idx_q] <= in_bus.in_data;
    end
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    pending_d  = pending_q;
    pend_cnt_d = pend_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loaded_d   = loaded_q;
    frame_d    = frame_q;
    count_d    = count_q;
    start_d    = transfer;

    if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end
    if (frame_done) begin
      pending_d  = 1'b1;
      pend_cnt_d = slot_count(wr_idx_q);
    end

    // accept and transfer are mutually exclusive: transfer needs pending, accept needs !pending.
    if (transfer) begin
      frame_d    = padded;
      count_d    = pend_cnt_q;
      hold_cnt_d = hold_t'(SORT_LATENCY);
      pending_d  = 1'b0;
      wr_idx_d   = '0;
      loaded_d   = 1'b1;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q   <= '0;
      pending_q  <= 1'b0;
      pend_cnt_q <= '0;
      hold_cnt_q <= '0;
      loaded_q   <= 1'b0;
      frame_q    <= '{default: '0};
      count_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      loaded_q   <= loaded_d;
      frame_q    <= frame_d;
      count_q    <= count_d;
      start_q    <= start_d;
    end
  end

  assign frame_out     = frame_q;
  assign frame_count   = count_q;
  assign frame_start   = start_q;
  assign frame_settled = loaded_q && (hold_cnt_q == '0);

endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Self-checking bench for bitonic_frame_loader: table of frames plus hand sequences,
// with a scoreboard of expected frames popped on every frame_start.
module tb_bitonic_frame_loader;
  import bitonic_pkg::*;

  typedef struct {
    int     nbeats;
    bit     last;
    bit     bubbles;
    frame_t beat;
    int     exp_cnt;
    frame_t exp;
  } vec_t;

  typedef struct {
    frame_t d;
    int     cnt;
  } exp_t;

  logic   clk;
  logic   rst_n;
  frame_t frame_out;
  cnt_t   frame_count;
  logic   frame_start;
  logic   frame_settled;

  int tests;
  int fails;
  exp_t exp_q[$];
  vec_t vecs [0:5];

  bitonic_frame_loader_if bus ();

  bitonic_frame_loader #(.SORT_LATENCY(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_bus        (bus),
    .frame_out     (frame_out),
    .frame_count   (frame_count),
    .frame_start   (frame_start),
    .frame_settled (frame_settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Each frame_start pops one expected frame.
  always @(negedge clk) begin : mon
    exp_t e;
    int   bad;
    if (rst_n && frame_start) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got frame_start with count %0d, required no load", frame_count);
      end else begin
        e = exp_q.pop_front();
        bad = -1;
        for (int i = 0; i < N; i++) begin
          if (bad < 0 && frame_out[i] !== e.d[i]) bad = i;
        end
        tests++;
        if (bad >= 0) begin
          fails++;
          $display("FAIL frame_data[%0d]: got %02h required %02h", bad, frame_out[bad], e.d[bad]);
        end else begin
          $display("[TB] ok frame loaded, count %0d, [0]=%02h [15]=%02h", frame_count, frame_out[0], frame_out[15]);
        end
        check("frame_count", 32'(frame_count), 32'(e.cnt));
        check("settled_low_at_load", 32'(frame_settled), 32'd0);
      end
    end
  end

  task automatic send_beat(input elem_t d, input bit l);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.d   = v.exp;
    e.cnt = v.exp_cnt;
    exp_q.push_back(e);
    for (int b = 0; b < v.nbeats; b++) begin
      send_beat(v.beat[b], v.last && (b == v.nbeats - 1));
      if (v.bubbles) begin
        bus.in_data = 8'hAA;
        bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_last = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !frame_settled) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : main
    exp_t e;
    logic any_nz;
    tests = 0;
    fails = 0;

    vecs[0].nbeats = 16; vecs[0].last = 0; vecs[0].bubbles = 0; vecs[0].exp_cnt = 16;
    vecs[0].beat = '{8'h03, 8'h05, 8'h08, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h14,
                     8'h5F, 8'h5A, 8'h3C, 8'h28, 8'h23, 8'h17, 8'h12, 8'h00};
    vecs[0].exp  = vecs[0].beat;

    vecs[1].nbeats = 5; vecs[1].last = 1; vecs[1].bubbles = 0; vecs[1].exp_cnt = 5;
    vecs[1].beat = '{0: 8'h10, 1: 8'h11, 2: 8'h12, 3: 8'h13, 4: 8'h14, default: 8'h00};
    vecs[1].exp  = '{0: 8'h10, 1: 8'h11, 2: 8'h12, 3: 8'h13, 4: 8'h14, default: 8'hFF};

    vecs[2].nbeats = 1; vecs[2].last = 1; vecs[2].bubbles = 0; vecs[2].exp_cnt = 1;
    vecs[2].beat = '{0: 8'h42, default: 8'h00};
    vecs[2].exp  = '{0: 8'h42, default: 8'hFF};

    // in_last on slot N-1 is an ordinary full frame.
    vecs[3].nbeats = 16; vecs[3].last = 1; vecs[3].bubbles = 0; vecs[3].exp_cnt = 16;
    vecs[4].nbeats = 16; vecs[4].last = 0; vecs[4].bubbles = 1; vecs[4].exp_cnt = 16;
    vecs[5].nbeats = 16; vecs[5].last = 0; vecs[5].bubbles = 0; vecs[5].exp_cnt = 16;
    for (int i = 0; i < N; i++) begin
      vecs[3].beat[i] = elem_t'(8'h80 + i);
      vecs[4].beat[i] = elem_t'(i * 7 + 1);
      vecs[5].beat[i] = elem_t'(8'hF0 - i * 3);
    end
    for (int v = 3; v <= 5; v++) vecs[v].exp = vecs[v].beat;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_settled", 32'(frame_settled), 32'd0);
    check("rst_frame_out0", 32'(frame_out[0]), 32'd0);

    // Full frame: load one edge after the final accept, settle four cycles later.
    send_frame(vecs[0]);
    check("full_start_not_yet", 32'(frame_start), 32'd0);
    check("full_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("full_start", 32'(frame_start), 32'd1);
    check("full_ready_back", 32'(bus.in_ready), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) check("full_start_one_cycle", 32'(frame_start), 32'd0);
      check($sformatf("full_settled_c%0d", c), 32'(frame_settled), 32'(c == 4));
    end

    // Table frames sent back to back: each overlaps the previous frame's hold.
    for (int v = 1; v <= 5; v++) begin
      $display("[TB] table frame %0d: %0d beats last=%0d bubbles=%0d", v, vecs[v].nbeats, vecs[v].last, vecs[v].bubbles);
      send_frame(vecs[v]);
    end
    wait_idle();

    // Short frame completes during a hold: in_ready stays low and frame_out holds.
    for (int i = 0; i < N; i++) e.d[i] = elem_t'(8'h20 + i);
    e.cnt = 16;
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) send_beat(elem_t'(8'h20 + i), 1'b0);
    e.d   = '{0: 8'h61, 1: 8'h62, default: 8'hFF};
    e.cnt = 2;
    exp_q.push_back(e);
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b1);
    check("stall_ready_low", 32'(bus.in_ready), 32'd0);
    check("stall_count_old", 32'(frame_count), 32'd16);
    for (int g = 0; g < 20 && !frame_settled; g++) begin
      check("hold_ready_low", 32'(bus.in_ready), 32'd0);
      check("hold_frame_stable", 32'(frame_out[15]), 32'h2F);
      @(negedge clk);
    end
    check("settled_before_load", 32'(frame_settled), 32'd1);
    check("ready_low_until_load", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("second_start", 32'(frame_start), 32'd1);
    check("settled_fell", 32'(frame_settled), 32'd0);
    check("ready_after_load", 32'(bus.in_ready), 32'd1);
    wait_idle();

    // Reset mid-fill, between clock edges.
    for (int i = 0; i < 7; i++) send_beat(elem_t'(8'hC0 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    any_nz = 1'b0;
    for (int i = 0; i < N; i++) if (frame_out[i] != '0) any_nz = 1'b1;
    check("async_frame_out_zero", 32'(any_nz), 32'd0);
    check("async_frame_count", 32'(frame_count), 32'd0);
    check("async_frame_settled", 32'(frame_settled), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) e.d[i] = elem_t'(8'h70 + i);
    e.cnt = 16;
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) send_beat(elem_t'(8'h70 + i), 1'b0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
